// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: control, stimulus and result signals between a sweep controller and its caller
interface truth_table_sequencer_if;
  logic       start, abort, f_in, a, b, c, busy, done, match;
  logic [7:0] expected, table_out;
  modport master(output start, abort, expected, f_in, input a, b, c, busy, done, table_out, match);
  modport slave(input start, abort, expected, f_in, output a, b, c, busy, done, table_out, match);
endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks {a,b,c} through 000..111, samples f after a settle delay, builds and checks an 8-bit truth table
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                     clk,
  input logic                     reset,
  truth_table_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam state_t     FIRST    = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  state_t     state_q;
  logic [2:0] idx_q, abc_q;
  logic [3:0] cnt_q;
  logic       busy_q, done_q, match_q;
  logic [7:0] tbl_q, tbl_d, exp_q;
  always_comb begin
    tbl_d = tbl_q;
    tbl_d[idx_q] = bus.f_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      tbl_q   <= '0;
      exp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= FIRST;
          idx_q   <= '0;
          cnt_q   <= '0;
          abc_q   <= '0;
          busy_q  <= 1'b1;
          match_q <= 1'b0;
          tbl_q   <= '0;
          exp_q   <= bus.expected;
        end
        SETTLE: if (bus.abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          abc_q   <= '0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else if (cnt_q == CNT_LAST) begin
          state_q <= SAMPLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        SAMPLE: if (bus.abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          abc_q   <= '0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else if (idx_q == 3'd7) begin
          tbl_q   <= tbl_d;
          state_q <= DONE;
          done_q  <= 1'b1;
          match_q <= (tbl_d == exp_q);
        end else begin
          tbl_q   <= tbl_d;
          idx_q   <= idx_q + 3'd1;
          abc_q   <= idx_q + 3'd1;
          state_q <= FIRST;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          abc_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {bus.a, bus.b, bus.c} = abc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match     = match_q;
  assign bus.table_out = tbl_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: runs a SETTLE_CYCLES=2 and a SETTLE_CYCLES=0 sequencer side by side against a cycle-offset model
module tb_truth_table_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, abort, en = 1'b0;
  logic [7:0] expected, lut;
  logic [1:0] mode;
  int         tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  truth_table_sequencer_if bus0 ();
  truth_table_sequencer_if bus1 ();
  truth_table_sequencer #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  truth_table_sequencer #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  function automatic logic circ(input logic [2:0] v, input logic [1:0] m, input logic [7:0] l);
    circ = m == 2'd0 ? ((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])) : m == 2'd1 ? ^v : l[v];
  endfunction
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.abort = abort;
  assign bus1.abort = abort;
  assign bus0.expected = expected;
  assign bus1.expected = expected;
  assign bus0.f_in = circ({bus0.a, bus0.b, bus0.c}, mode, lut);
  assign bus1.f_in = circ({bus1.a, bus1.b, bus1.c}, mode, lut);
  logic [13:0] dout [2];
  assign dout[0] = {bus0.a, bus0.b, bus0.c, bus0.busy, bus0.done, bus0.match, bus0.table_out};
  assign dout[1] = {bus1.a, bus1.b, bus1.c, bus1.busy, bus1.done, bus1.match, bus1.table_out};
  // Model: a sweep is a count p of edges since start; vector p/(S+1) is sampled when p%(S+1)==S
  logic [2:0] m_abc [2];
  logic [7:0] m_tbl [2], m_exp [2];
  logic       m_busy [2], m_done [2], m_match [2], m_act [2], m_dc [2];
  int         m_p [2], t0 [2], lat [2], dcnt [2];
  int         ms, mv;
  logic       mf;
  initial for (int i = 0; i < 2; i++) begin
    m_abc[i] = 0; m_tbl[i] = 0; m_exp[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_match[i] = 0;
    m_act[i] = 0; m_dc[i] = 0; m_p[i] = 0; t0[i] = 0; lat[i] = 0; dcnt[i] = 0;
  end
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ms = (i == 0) ? 2 : 0;
      mf = circ(m_abc[i], mode, lut);
      if (reset) begin
        m_act[i] = 0; m_dc[i] = 0; m_abc[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        m_tbl[i] = 0; m_match[i] = 0; m_exp[i] = 0;
      end else if (m_dc[i]) begin
        m_dc[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_abc[i] = 0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1; m_p[i] = 0; m_tbl[i] = 0; m_match[i] = 0; m_exp[i] = expected;
          m_busy[i] = 1; m_abc[i] = 0; t0[i] = cyc - 1;
        end
      end else if (abort) begin
        m_act[i] = 0; m_busy[i] = 0; m_abc[i] = 0;
      end else begin
        mv = m_p[i] / (ms + 1);
        if (m_p[i] % (ms + 1) == ms) begin
          m_tbl[i][mv] = mf;
          if (mv == 7) begin
            m_act[i] = 0; m_dc[i] = 1; m_done[i] = 1; m_match[i] = (m_tbl[i] == m_exp[i]);
          end else m_abc[i] = 3'(mv + 1);
        end
        m_p[i]++;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  always @(negedge clk) if (en) for (int i = 0; i < 2; i++) begin
    chk($sformatf("outs%0d", i), 32'(dout[i]),
        32'({m_abc[i], m_busy[i], m_done[i], m_match[i], m_tbl[i]}));
    if (dout[i][9] === 1'b1) begin
      lat[i] = cyc - t0[i];
      dcnt[i]++;
    end
  end
  task automatic run(input logic [7:0] e, input int n, input int ab, input int rk, input logic multi);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      expected = e;
      start = (k == 0) || (multi && (k == 5 || (k >= 24 && k <= 26)));
      abort = (k == ab);
      reset = (k == rk);
    end
    @(negedge clk);
    start = 0; abort = 0; reset = 0;
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  int d;
  initial begin
    reset = 1; start = 0; abort = 0; expected = 0; mode = 0; lut = 0;
    repeat (2) @(negedge clk);
    en = 1;
    #1;
    chk("reset_tbl", 32'(bus0.table_out), 32'h00);
    chk("reset_busy", 32'(bus0.busy), 32'h0);
    reset = 0;
    run(8'hE8, 30, -1, -1, 0);
    chk("maj_lat", lat[0], 25);
    chk("maj_lat_s0", lat[1], 9);
    chk("maj_tbl", 32'(bus0.table_out), 32'hE8);
    chk("maj_match", 32'(bus0.match), 32'h1);
    chk("maj_tbl_s0", 32'(bus1.table_out), 32'hE8);
    run(8'hE9, 30, -1, -1, 0);
    chk("maj_nomatch", 32'(bus0.match), 32'h0);
    chk("maj_tbl2", 32'(bus0.table_out), 32'hE8);
    chk("maj_lat2", lat[0], 25);
    mode = 1;
    run(8'h96, 30, -1, -1, 0);
    chk("xor_tbl", 32'(bus0.table_out), 32'h96);
    chk("xor_match", 32'(bus0.match), 32'h1);
    mode = 0;
    d = dcnt[0];
    run(8'hE8, 27, -1, -1, 1);
    chk("restart_dones", dcnt[0] - d, 1);
    chk("restart_lat", lat[0], 25);
    chk("restart_busy", 32'(bus0.busy), 32'h1);
    idle(30);
    chk("restart2_lat", lat[0], 25);
    mode = 1;
    d = dcnt[0];
    run(8'h96, 15, 10, -1, 0);
    chk("abort_tbl", 32'(bus0.table_out), 32'h06);
    chk("abort_match", 32'(bus0.match), 32'h0);
    chk("abort_busy", 32'(bus0.busy), 32'h0);
    chk("abort_abc", 32'({bus0.a, bus0.b, bus0.c}), 32'h0);
    chk("abort_nodone", dcnt[0] - d, 0);
    run(8'h96, 30, -1, -1, 0);
    chk("post_abort_match", 32'(bus0.match), 32'h1);
    mode = 0;
    run(8'hE8, 15, -1, 12, 0);
    chk("rst_tbl", 32'(bus0.table_out), 32'h00);
    chk("rst_busy", 32'(bus0.busy), 32'h0);
    run(8'hE8, 30, -1, -1, 0);
    chk("post_rst_lat", lat[0], 25);
    chk("post_rst_match", 32'(bus0.match), 32'h1);
    mode = 2;
    lut = 8'($urandom);
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) lut = 8'($urandom);
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      expected = $urandom_range(0, 1) ? lut : 8'($urandom);
    end
    @(negedge clk);
    start = 0; abort = 0; reset = 0;
    idle(30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Controller that drives the 3-input combinational test circuit (inputs a,b,c; output f) through all 8 input combinations in order. It waits a programmable settle time per vector, samples f, and assembles an 8-bit truth table. The table is compared with a caller-supplied expected value and reported with a done pulse. This replaces hand-written stimulus sequences with a reusable, clocked self-check block in the lab datapath.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before f is sampled (legal 0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  8  expected truth table, latched when start is accepted
f_in  input  1  output f of the circuit under control
a  output  1  circuit input a (MSB of vector index)
b  output  1  circuit input b
c  output  1  circuit input c (LSB of vector index)
busy  output  1  high from the cycle after start is accepted until the DONE state
done  output  1  one-cycle pulse when the sweep completes
table_out  output  8  bit i = f sampled with {a,b,c}=i
match  output  1  table_out == latched expected, valid from done until next accepted start

Behaviour:
- Reset (synchronous, reset=1 at rising edge) forces state=IDLE, idx=0, cnt=0, {a,b,c}=000, busy=0, done=0, table_out=8'h00, match=0, and latched expected=8'h00. Reset overrides all other inputs, including mid-sweep.
- States are IDLE, SETTLE, SAMPLE and DONE. idx is 3 bits; cnt is 4 bits.
- IDLE: if start=1, then idx<=0, {a,b,c}<=000, table_out<=0, match<=0, expected latched, cnt<=0, busy<=1. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: if cnt==SETTLE_CYCLES-1, go to SAMPLE and set cnt<=0; otherwise cnt<=cnt+1. {a,b,c} is held at idx.
- SAMPLE: table_out[idx]<=f_in.
  - If idx==7, go to DONE.
  - Otherwise idx<=idx+1, {a,b,c}<=idx+1, and go to SETTLE (or stay in SAMPLE when SETTLE_CYCLES==0).
- DONE: done=1 for exactly this cycle. match is registered as (table_out==expected) using the completed table, so it is valid in the DONE cycle. busy<=0, {a,b,c}<=000, next state IDLE. start is ignored in the DONE cycle.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done is asserted exactly 8*(SETTLE_CYCLES+1)+1 cycles after the cycle in which start was sampled high (25 cycles for the default).
- start while busy or in DONE is ignored and has no effect on timing.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE, busy<=0, {a,b,c}<=000, cnt<=0, idx<=0.
  - done is not pulsed, match stays 0, and table_out holds the partial bits.
  - abort in IDLE or DONE has no effect. If start and abort are both high in IDLE, start wins.
- table_out, match and the latched expected hold their values while in IDLE until the next accepted start.
- f_in is treated as settled combinational data. No synchronizer is included.

Test Plan:
1. Majority circuit on f_in, expected=8'hE8, start pulsed once. Required: vectors 000..111 each held 3 cycles; done exactly 25 cycles after start; table_out=8'hE8; match=1; busy low in the cycle after done.
2. Same circuit, expected=8'hE9. Required: table_out=8'hE8, match=0, done timing unchanged. Repeat with a 3-input XOR circuit and expected=8'h96: table_out=8'h96, match=1.
3. start re-pulsed at cycles 5 and 24 of a sweep, plus start held high through the DONE cycle. Required: done still at cycle 25 with a single pulse. A new sweep is accepted only from start in IDLE on the following cycle.
4. abort at cycle 10 (vector idx=3 in progress). Required: busy=0 and {a,b,c}=000 next cycle; no done; match=0; table_out[2:0] holds the sampled bits and the upper bits are 0. A subsequent start completes normally.
5. reset asserted at cycle 12 mid-sweep. Required: all outputs at reset values on the next edge. A later start with expected=8'hE8 gives done at 25 cycles and match=1.
6. SETTLE_CYCLES=0 build, majority circuit. Required: one cycle per vector; done 9 cycles after start; table_out=8'hE8.
